// File: rtl/rx_uart.sv
// Oversampling 8N1 serial receiver with a small read FIFO and sticky error flags.
// Define RX_UART_PARITY_EN to receive 8E1 frames and report parity errors in status[4].
module rx_uart #(
   parameter int FIFO_DEPTH      = 4,
   parameter int DEFAULT_DIVISOR = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_line,
   input  logic [7:0] config_data,
   input  logic       config_enable,
   input  logic       read_enable,
   input  logic       clear_errors,
   output logic [7:0] rx_data,
   output logic [7:0] status
);

   localparam int AW = $clog2(FIFO_DEPTH);

`ifdef RX_UART_PARITY_EN
   typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state, state_n;
   logic [1:0]    sync;
   logic          rx_s;
   logic [7:0]    div_q, eff_div, nper, cnt, shreg;
   logic [2:0]    bit_idx;
   logic          tick;
   logic          load_half, load_full, shift_en, push, set_fe, set_pe, par_cap;
   logic          parity_bad, parity_err, frame_err, overrun;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, pop_ok, push_ok;

   assign rx_s    = sync[1];
   assign eff_div = (div_q < 8'd2) ? 8'd2 : div_q;
   assign tick    = (cnt == 8'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b11;
         div_q <= 8'(DEFAULT_DIVISOR);
      end else begin
         sync <= {sync[0], rx_line};
         if (config_enable) div_q <= config_data;
      end
   end

`ifdef RX_UART_PARITY_EN
   logic par_bit, parity_err_q;
   assign parity_bad = ^{shreg, par_bit};
   assign parity_err = parity_err_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bit      <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         if (par_cap) par_bit <= rx_s;
         parity_err_q <= set_pe | (parity_err_q & ~clear_errors);
      end
   end
`else
   assign parity_bad = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ARM;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      load_half = 1'b0;
      load_full = 1'b0;
      shift_en  = 1'b0;
      push      = 1'b0;
      set_fe    = 1'b0;
      set_pe    = 1'b0;
      par_cap   = 1'b0;
      case (state)
         ARM:   if (rx_s) state_n = IDLE;
         IDLE:  if (!rx_s) begin
                   load_half = 1'b1;
                   state_n   = START;
                end
         START: if (tick) begin
                   if (!rx_s) begin
                      load_full = 1'b1;
                      state_n   = DATA;
                   end else begin
                      state_n = IDLE;
                   end
                end
         DATA:  if (tick) begin
                   shift_en  = 1'b1;
                   load_full = 1'b1;
`ifdef RX_UART_PARITY_EN
                   if (bit_idx == 3'd7) state_n = PARITY;
`else
                   if (bit_idx == 3'd7) state_n = STOP;
`endif
                end
`ifdef RX_UART_PARITY_EN
         PARITY: if (tick) begin
                   par_cap   = 1'b1;
                   load_full = 1'b1;
                   state_n   = STOP;
                end
`endif
         STOP:  if (tick) begin
                   // A low stop bit may be a break; re-arm so the held line is not read as bytes
                   if (!rx_s) begin
                      set_fe  = 1'b1;
                      state_n = ARM;
                   end else if (parity_bad) begin
                      set_pe  = 1'b1;
                      state_n = IDLE;
                   end else begin
                      push    = 1'b1;
                      state_n = IDLE;
                   end
                end
         default: state_n = ARM;
      endcase
   end

   // Bit period is latched at start detect so divisor writes only affect later frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nper    <= 8'd2;
         cnt     <= 8'd0;
         shreg   <= 8'd0;
         bit_idx <= 3'd0;
      end else begin
         if (load_half) begin
            nper    <= eff_div;
            cnt     <= {1'b0, eff_div[7:1]};
            bit_idx <= 3'd0;
         end else if (load_full) begin
            cnt <= nper;
         end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
         if (shift_en) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = read_enable && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         frame_err <= set_fe | (frame_err & ~clear_errors);
         overrun   <= (push & ~push_ok) | (overrun & ~clear_errors);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
   end

   assign rx_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
   assign status  = {3'b000, parity_err, frame_err, overrun, full, !empty};

endmodule

// File: tb/tb_rx_uart.sv
// Scoreboard bench for rx_uart: stimulus queues expected bytes and register snapshots,
// a negedge monitor performs every comparison.
module tb_rx_uart;

   logic       clk = 1'b0;
   logic       rst, rx_line, config_enable, read_enable, clear_errors;
   logic [7:0] config_data, rx_data, status;

   always #5 clk = ~clk;

`ifdef RX_UART_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   rx_uart dut (
      .clk(clk), .rst(rst), .rx_line(rx_line), .config_data(config_data),
      .config_enable(config_enable), .read_enable(read_enable),
      .clear_errors(clear_errors), .rx_data(rx_data), .status(status)
   );

   // kind 0: status == exp, kind 1: rx_data == exp, kind 2: exp <= act <= hi
   typedef struct {
      string name;
      int    kind;
      int    exp;
      int    act;
      int    hi;
   } chk_t;

   logic [7:0] exp_q [$];
   chk_t       chk_q [$];
   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] mon_e;
   chk_t       mon_c;

   always @(negedge clk) begin
      if (!rst && read_enable && status[0]) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: rx_data=%02h but no byte expected", rx_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (rx_data !== mon_e) begin
               n_fail++;
               $display("FAIL pop_data: rx_data=%02h expected=%02h", rx_data, mon_e);
            end
         end
      end
      while (chk_q.size() > 0) begin
         mon_c = chk_q.pop_front();
         n_cmp++;
         case (mon_c.kind)
            0: if (status !== mon_c.exp[7:0]) begin
                  n_fail++;
                  $display("FAIL %s: status=%02h expected=%02h", mon_c.name, status, mon_c.exp[7:0]);
               end
            1: if (rx_data !== mon_c.exp[7:0]) begin
                  n_fail++;
                  $display("FAIL %s: rx_data=%02h expected=%02h", mon_c.name, rx_data, mon_c.exp[7:0]);
               end
            default: if (mon_c.act < mon_c.exp || mon_c.act > mon_c.hi) begin
                  n_fail++;
                  $display("FAIL %s: value=%0d expected range %0d..%0d", mon_c.name, mon_c.act, mon_c.exp, mon_c.hi);
               end
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_out(input logic v, input int n);
      rx_line = v;
      tick(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input int n, input logic stop_v, input logic par_flip);
      bit_out(1'b0, n);
      for (int i = 0; i < 8; i++) bit_out(b[i], n);
      if (PB == 1) bit_out((^b) ^ par_flip, n);
      bit_out(stop_v, n);
   endtask

   task automatic pop();
      read_enable = 1'b1;
      tick(1);
      read_enable = 1'b0;
   endtask

   task automatic clr();
      clear_errors = 1'b1;
      tick(1);
      clear_errors = 1'b0;
   endtask

   task automatic expect_reg(input string nm, input int kind, input logic [7:0] v);
      chk_t c;
      c.name = nm; c.kind = kind; c.exp = int'(v); c.act = 0; c.hi = 0;
      chk_q.push_back(c);
      tick(1);
   endtask

   task automatic expect_range(input string nm, input int act, input int lo, input int hi);
      chk_t c;
      c.name = nm; c.kind = 2; c.exp = lo; c.act = act; c.hi = hi;
      chk_q.push_back(c);
      tick(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst = 1'b1; rx_line = 1'b1; config_data = 8'h00; config_enable = 1'b0;
      read_enable = 1'b0; clear_errors = 1'b0;
      tick(3);
      expect_reg("reset_status", 0, 8'h00);
      expect_reg("reset_data", 1, 8'h00);
      rst = 1'b0;
      tick(5);
      expect_reg("post_reset_status", 0, 8'h00);

      // Default divisor 16: latency from falling edge to not_empty
      exp_q.push_back(8'hA5);
      lat = 0;
      fork
         send_frame(8'hA5, 16, 1'b1, 1'b0);
         begin
            while (!status[0] && lat < 400) begin
               tick(1);
               lat++;
            end
         end
      join
      expect_range("a5_latency", lat, 153 + 16*PB, 156 + 16*PB);
      expect_reg("a5_head", 1, 8'hA5);
      pop();
      expect_reg("a5_popped_status", 0, 8'h00);
      expect_reg("a5_popped_data", 1, 8'h00);

      // Divisor 8, back-to-back frames
      config_data = 8'd8; config_enable = 1'b1;
      tick(1);
      config_enable = 1'b0;
      tick(4);
      exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
      send_frame(8'h3C, 8, 1'b1, 1'b0);
      send_frame(8'hC3, 8, 1'b1, 1'b0);
      tick(10);
      expect_reg("b2b_status", 0, 8'h01);
      pop(); pop();
      expect_reg("b2b_drained", 0, 8'h00);

      // Overrun: depth+1 bytes without popping
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      send_frame(8'h11, 8, 1'b1, 1'b0);
      send_frame(8'h22, 8, 1'b1, 1'b0);
      send_frame(8'h33, 8, 1'b1, 1'b0);
      send_frame(8'h44, 8, 1'b1, 1'b0);
      send_frame(8'h55, 8, 1'b1, 1'b0);
      tick(10);
      expect_reg("overrun_status", 0, 8'h07);
      expect_reg("overrun_head", 1, 8'h11);
      clr();
      expect_reg("overrun_cleared", 0, 8'h03);
      pop(); pop(); pop(); pop();
      expect_reg("overrun_drained", 0, 8'h00);

      // Pop coincident with the push of the 5th byte while full
      exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
      exp_q.push_back(8'hA4); exp_q.push_back(8'hB5);
      send_frame(8'hA1, 8, 1'b1, 1'b0);
      send_frame(8'hA2, 8, 1'b1, 1'b0);
      send_frame(8'hA3, 8, 1'b1, 1'b0);
      send_frame(8'hA4, 8, 1'b1, 1'b0);
      fork
         send_frame(8'hB5, 8, 1'b1, 1'b0);
         begin
            tick(78 + 8*PB);
            read_enable = 1'b1;
            tick(1);
            read_enable = 1'b0;
         end
      join
      expect_reg("simul_status", 0, 8'h03);
      expect_reg("simul_head", 1, 8'hA2);
      pop(); pop(); pop(); pop();
      expect_reg("simul_drained", 0, 8'h00);

      // Framing error followed by a held-low line
      send_frame(8'hF0, 8, 1'b0, 1'b0);
      tick(40);
      expect_reg("frame_err_status", 0, 8'h08);
      rx_line = 1'b1;
      tick(20);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 8, 1'b1, 1'b0);
      tick(10);
      expect_reg("after_break_status", 0, 8'h09);
      pop();
      clr();
      expect_reg("frame_err_cleared", 0, 8'h00);

      // Short glitch on idle line is a false start
      rx_line = 1'b0;
      tick(2);
      rx_line = 1'b1;
      tick(30);
      expect_reg("glitch_status", 0, 8'h00);

      if (PB == 1) begin
         send_frame(8'h01, 8, 1'b1, 1'b1);
         tick(10);
         expect_reg("parity_err_status", 0, 8'h10);
         clr();
         expect_reg("parity_err_cleared", 0, 8'h00);
      end

      expect_range("scoreboard_drained", exp_q.size(), 0, 0);
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
